// File: rtl/bounce_emu_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_emu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Fibonacci feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (left shift)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR used as a pseudo-random toggle source while bouncing.
module bounce_lfsr
  import bounce_emu_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bounce_emulator.sv
// Emulates a bouncing switch bus settling onto a requested clean value.
// Define BOUNCE_EMU_LFSR_EN to take toggle bits from an LFSR instead of an alternating phase.
module bounce_emulator
  import bounce_emu_pkg::*;
#(
  parameter int              WIDTH      = 4,
  parameter int              BOUNCE_LEN = 16,
  parameter int              HOLD_LEN   = 8,
  parameter logic [15:0]     SEED       = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic [WIDTH-1:0] dataBouncy,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] src;
  logic             accept;
  logic             in_bounce;

  assign accept       = (state_q == IDLE) && target_valid;
  assign in_bounce    = (state_q == BOUNCE);
  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dataBouncy   = data_q;
  assign done         = done_q;

`ifdef BOUNCE_EMU_LFSR_EN
  logic [15:0] lfsr_state;
  logic        lfsr_unused;

  bounce_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (in_bounce),
    .state   (lfsr_state)
  );

  assign src         = lfsr_state[WIDTH-1:0];
  assign lfsr_unused = ^lfsr_state;
`else
  logic phase_q;

  // Phase starts at 1 on the first bounce cycle and alternates thereafter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else if (accept) begin
      phase_q <= 1'b1;
    end else if (in_bounce) begin
      phase_q <= ~phase_q;
    end
  end

  assign src = {WIDTH{phase_q}};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      tgt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d  = target;
          mask_d = target ^ data_q;
          if (|(target ^ data_q)) begin
            state_d = BOUNCE;
            cnt_d   = 8'(BOUNCE_LEN - 1);
          end else begin
            state_d = HOLD;
            cnt_d   = 8'(HOLD_LEN - 1);
          end
        end
      end
      BOUNCE: begin
        if (cnt_q != 8'd0) begin
          // Unchanged bits hold; changed bits show target or its inverse
          data_d = (data_q & ~mask_q) | (mask_q & ~(src ^ tgt_q));
          cnt_d  = cnt_q - 8'd1;
        end else begin
          data_d  = tgt_q;
          state_d = HOLD;
          cnt_d   = 8'(HOLD_LEN - 1);
        end
      end
      HOLD: begin
        data_d = tgt_q;
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_emulator.sv
// Self-checking bench for bounce_emulator: directed scenarios plus random traffic against a model.
module tb_bounce_emulator;

  localparam int          W    = 4;
  localparam int          BL   = 16;
  localparam int          HL   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] target;
  logic         target_valid;
  logic         target_ready;
  logic [W-1:0] dataBouncy;
  logic         busy;
  logic         done;

  bounce_emulator #(
    .WIDTH      (W),
    .BOUNCE_LEN (BL),
    .HOLD_LEN   (HL),
    .SEED       (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .dataBouncy   (dataBouncy),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Transaction-level model: outputs are a function of cycles elapsed since accept
  logic         m_act;
  int           m_n;
  int           m_total;
  logic [W-1:0] m_tgt, m_start, m_mask, m_data;
  logic         m_done;
  logic [15:0]  m_lfsr, m_snap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s0, input int k);
    logic [15:0] s;
    s = s0;
    for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic logic [W-1:0] src_at(input int n);
`ifdef BOUNCE_EMU_LFSR_EN
    logic [15:0] s;
    s = lfsr_adv(m_snap, n - 1);
    return s[W-1:0];
`else
    return {W{n[0]}};
`endif
  endfunction

  task automatic model_reset();
    m_act   = 1'b0;
    m_n     = 0;
    m_total = 0;
    m_tgt   = '0;
    m_start = '0;
    m_mask  = '0;
    m_data  = '0;
    m_done  = 1'b0;
    m_lfsr  = SEED;
    m_snap  = SEED;
  endtask

  task automatic model_edge();
    if (reset) return;
    m_done = 1'b0;
    if (!m_act) begin
      if (target_valid) begin
        m_act   = 1'b1;
        m_n     = 0;
        m_tgt   = target;
        m_start = m_data;
        m_mask  = target ^ m_data;
        m_total = (m_mask != '0) ? BL + HL : HL;
        m_snap  = m_lfsr;
      end
    end else begin
      m_n++;
      if (m_mask != '0)
        m_data = (m_n < BL) ? ((m_start & ~m_mask) | (m_mask & ~(src_at(m_n) ^ m_tgt))) : m_tgt;
      if (m_n == m_total) begin
        m_act  = 1'b0;
        m_done = 1'b1;
        if (m_mask != '0) m_lfsr = lfsr_adv(m_snap, BL);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_data",  {28'd0, dataBouncy}, {28'd0, m_data});
      chk("model_ready", {31'd0, target_ready}, {31'd0, !m_act});
      chk("model_busy",  {31'd0, busy}, {31'd0, m_act});
      chk("model_done",  {31'd0, done}, {31'd0, m_done});
    end
  end

  initial begin
    reset        = 1'b1;
    target       = '0;
    target_valid = 1'b0;
    model_reset();
    #100;
    chk("rst_data",  {28'd0, dataBouncy}, 32'h0);
    chk("rst_ready", {31'd0, target_ready}, 32'h1);
    chk("rst_busy",  {31'd0, busy}, 32'h0);
    chk("rst_done",  {31'd0, done}, 32'h0);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Bounce from 0 to 4, with an ignored offer of F during the run
    target = 4'h4; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    for (int n = 1; n <= BL + HL + 1; n++) begin
      tick();
      if (n == 4) begin target = 4'hF; target_valid = 1'b1; end
      if (n == 5) target_valid = 1'b0;
`ifndef BOUNCE_EMU_LFSR_EN
      if (n < BL) chk("a_bit2", {31'd0, dataBouncy[2]}, (n % 2 == 1) ? 32'h1 : 32'h0);
`endif
      if (n < BL) chk("a_quiet", {28'd0, dataBouncy & 4'hB}, 32'h0);
      if (n == BL) chk("a_settled", {28'd0, dataBouncy}, 32'h4);
      if (n == BL + HL - 1) chk("a_nodone_early", {31'd0, done}, 32'h0);
      if (n == BL + HL) chk("a_done", {31'd0, done}, 32'h1);
      if (n == BL + HL + 1) begin
        chk("a_done_once", {31'd0, done}, 32'h0);
        chk("a_final", {28'd0, dataBouncy}, 32'h4);
      end
    end

    // Same value again: hold only
    target = 4'h4; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    for (int n = 1; n <= HL; n++) begin
      tick();
      chk("b_data", {28'd0, dataBouncy}, 32'h4);
      chk("b_done", {31'd0, done}, (n == HL) ? 32'h1 : 32'h0);
    end
    tick();

    // Reset in the middle of bouncing aborts without a done pulse
    target = 4'h9; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("c_data",  {28'd0, dataBouncy}, 32'h0);
    chk("c_ready", {31'd0, target_ready}, 32'h1);
    chk("c_busy",  {31'd0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      chk("c_no_done", {31'd0, done}, 32'h0);
    end

    // Random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      target       = W'($urandom);
      target_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    target_valid = 1'b0;
    for (int n = 0; n < BL + HL + 2; n++) tick();
    chk("end_idle", {31'd0, target_ready}, 32'h1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
